// File: rtl/plg_gen.sv
// rtl/plg_gen.sv - payload segment generator: frame buffer, block padding, beat serialiser
// Ports:
//   clk_p, rst                          clock (rising edge), asynchronous active-high reset
//   din, din_vld, din_last, din_rdy     DIN_W-bit word input from the MAC side
//   dout, dout_vld, dout_last, dout_pad DOUT_W-bit beat output, LSB of the frame first
//   dout_rdy                            downstream back-pressure
//   busy                                a frame is loading or draining
//   ovf_err                             one-cycle pulse when a frame overflowed the buffer
module plg_gen #(
   parameter int DIN_W      = 8,
   parameter int DOUT_W     = 1,
   parameter int BLK_BITS   = 512,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic              clk_p,
   input  logic              rst,
   input  logic [DIN_W-1:0]  din,
   input  logic              din_vld,
   input  logic              din_last,
   output logic              din_rdy,
   output logic [DOUT_W-1:0] dout,
   output logic              dout_vld,
   input  logic              dout_rdy,
   output logic              dout_last,
   output logic              dout_pad,
   output logic              busy,
   output logic              ovf_err
);

   localparam int WB = $clog2(DIN_W);
   localparam int BB = $clog2(BLK_BITS);
   localparam int LB = DEPTH_LOG2 + WB;
   localparam int AW = DEPTH_LOG2;
   // Bit counters must hold both a full buffer and a padded length that may exceed it.
   localparam int CW = ((LB > BB) ? LB : BB) + 1;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [AW:0]       wcnt_q, wcnt_d;
   logic [AW:0]       nwords_q, nwords_d;
   logic              bad_q, bad_d;
   logic              ovf_q, ovf_d;
   logic              vld_q, vld_d;
   logic [CW-1:0]     b_q, b_d;

   logic [DIN_W-1:0]  mem [2**AW];
   logic [DIN_W-1:0]  rdata_q;

   logic [CW-1:0]     data_bits, total_bits, last_b;
   logic              acc, full, wr_en, rd_en, is_pad, is_last;
   logic [AW-1:0]     raddr;

   assign data_bits  = CW'(nwords_q) << WB;
   assign total_bits = (data_bits + CW'(BLK_BITS - 1)) & ~CW'(BLK_BITS - 1);
   assign last_b     = total_bits - CW'(DOUT_W);

   // wcnt never exceeds 2^DEPTH_LOG2, so its MSB alone flags a full buffer.
   assign full    = wcnt_q[AW];
   assign din_rdy = (state_q != DRAIN);
   assign acc     = din_vld & din_rdy;
   assign wr_en   = acc & ~full;

   // Read address follows the next bit index, so rdata_q always holds the
   // word of the beat being presented and steps with no bubble.
   assign raddr   = AW'(b_d >> WB);
   assign is_pad  = (b_q >= data_bits);
   assign is_last = (b_q == last_b);

   always_ff @(posedge clk_p) begin
      if (wr_en) mem[wcnt_q[AW-1:0]] <= din;
      if (rd_en) rdata_q <= mem[raddr];
   end

   always_ff @(posedge clk_p or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         wcnt_q   <= '0;
         nwords_q <= '0;
         bad_q    <= 1'b0;
         ovf_q    <= 1'b0;
         vld_q    <= 1'b0;
         b_q      <= '0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         nwords_q <= nwords_d;
         bad_q    <= bad_d;
         ovf_q    <= ovf_d;
         vld_q    <= vld_d;
         b_q      <= b_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      nwords_d = nwords_q;
      bad_d    = bad_q;
      ovf_d    = 1'b0;
      vld_d    = vld_q;
      b_d      = b_q;
      rd_en    = 1'b0;
      case (state_q)
         IDLE, LOAD: begin
            if (acc) begin
               state_d = LOAD;
               if (full) bad_d = 1'b1;
               else      wcnt_d = wcnt_q + (AW+1)'(1);
               if (din_last) begin
                  wcnt_d = '0;
                  bad_d  = 1'b0;
                  if (bad_q | full) begin
                     // Overflowed frame is dropped without output.
                     ovf_d   = 1'b1;
                     state_d = IDLE;
                  end else begin
                     nwords_d = wcnt_q + (AW+1)'(1);
                     state_d  = DRAIN;
                     b_d      = '0;
                     vld_d    = 1'b0;
                  end
               end
            end
         end
         DRAIN: begin
            if (!vld_q) begin
               // First DRAIN cycle primes the read of word 0.
               rd_en = 1'b1;
               vld_d = 1'b1;
            end else if (dout_rdy) begin
               if (is_last) begin
                  state_d = IDLE;
                  vld_d   = 1'b0;
                  b_d     = '0;
               end else begin
                  b_d   = b_q + CW'(DOUT_W);
                  rd_en = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign dout      = (vld_q && !is_pad) ? rdata_q[b_q[WB-1:0] +: DOUT_W] : '0;
   assign dout_vld  = vld_q;
   assign dout_last = vld_q & is_last;
   assign dout_pad  = vld_q & is_pad;
   assign busy      = (state_q != IDLE);
   assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_plg_gen.sv
// tb/tb_plg_gen.sv - self-checking bench for plg_gen
module tb_plg_gen;
   logic clk_p = 1'b0;
   always #5 clk_p = ~clk_p;

   logic       rst;
   logic [7:0] din;
   logic       din_vld, din_last, dout_rdy;
   int         sel;

   logic       vld_a, vld_b, rdy_a, rdy_b;
   logic       din_rdy_a, dout_vld_a, dout_last_a, dout_pad_a, busy_a, ovf_a;
   logic [0:0] dout_a;
   logic       din_rdy_b, dout_vld_b, dout_last_b, dout_pad_b, busy_b, ovf_b;
   logic [1:0] dout_b;

   assign vld_a = din_vld & (sel == 0);
   assign vld_b = din_vld & (sel == 1);
   assign rdy_a = dout_rdy & (sel == 0);
   assign rdy_b = dout_rdy & (sel == 1);

   logic       o_din_rdy, o_vld, o_last, o_pad, o_busy, o_ovf;
   logic [1:0] o_dout;
   assign o_din_rdy = (sel == 0) ? din_rdy_a   : din_rdy_b;
   assign o_vld     = (sel == 0) ? dout_vld_a  : dout_vld_b;
   assign o_last    = (sel == 0) ? dout_last_a : dout_last_b;
   assign o_pad     = (sel == 0) ? dout_pad_a  : dout_pad_b;
   assign o_busy    = (sel == 0) ? busy_a      : busy_b;
   assign o_ovf     = (sel == 0) ? ovf_a       : ovf_b;
   assign o_dout    = (sel == 0) ? {1'b0, dout_a} : dout_b;

   plg_gen #(.DIN_W(8), .DOUT_W(1), .BLK_BITS(512), .DEPTH_LOG2(12)) u_a (
      .clk_p(clk_p), .rst(rst), .din(din), .din_vld(vld_a), .din_last(din_last),
      .din_rdy(din_rdy_a), .dout(dout_a), .dout_vld(dout_vld_a), .dout_rdy(rdy_a),
      .dout_last(dout_last_a), .dout_pad(dout_pad_a), .busy(busy_a), .ovf_err(ovf_a));

   plg_gen #(.DIN_W(8), .DOUT_W(2), .BLK_BITS(512), .DEPTH_LOG2(3)) u_b (
      .clk_p(clk_p), .rst(rst), .din(din), .din_vld(vld_b), .din_last(din_last),
      .din_rdy(din_rdy_b), .dout(dout_b), .dout_vld(dout_vld_b), .dout_rdy(rdy_b),
      .dout_last(dout_last_b), .dout_pad(dout_pad_b), .busy(busy_b), .ovf_err(ovf_b));

   typedef struct { logic [1:0] d; logic last; logic pad; } beat_t;
   typedef struct { int sel; int nwords; int fixed; int rnd; int exp_beats; int exp_pad_at; } vec_t;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] words[$];
   beat_t      got_q[$];
   beat_t      exp_q[$];
   beat_t      saved_q[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic load_words(input int fixed, input int n);
      words.delete();
      if (fixed == 1) begin
         words.push_back(8'hA5); words.push_back(8'h3C); words.push_back(8'hFF);
      end else if (fixed == 2) begin
         words.push_back(8'hB4);
      end else begin
         for (int i = 0; i < n; i++) words.push_back(8'($urandom_range(0, 255)));
      end
   endtask

   // Expected beats from the frame definition: bit stream LSB first, zero
   // filled up to the next whole 512-bit block, cut into dw-bit beats.
   task automatic build_model(input int dw);
      logic bits[$];
      int   data_bits, total;
      exp_q.delete();
      foreach (words[i]) for (int k = 0; k < 8; k++) bits.push_back(words[i][k]);
      data_bits = bits.size();
      total = ((data_bits + 511) / 512) * 512;
      while (bits.size() < total) bits.push_back(1'b0);
      for (int b = 0; b < total; b += dw) begin
         beat_t e;
         e.d = 2'b00;
         for (int k = 0; k < dw; k++) e.d[k] = bits[b + k];
         e.pad  = (b >= data_bits);
         e.last = (b + dw == total);
         exp_q.push_back(e);
      end
   endtask

   // Called one time unit after a rising edge; returns one after a rising edge.
   task automatic send_words(input int gaps);
      for (int i = 0; i < words.size(); i++) begin
         if (gaps != 0 && $urandom_range(0, 3) == 0) begin
            din_vld = 1'b0;
            din_last = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk_p);
            #1;
         end
         din      = words[i];
         din_vld  = 1'b1;
         din_last = (i == words.size() - 1);
         @(posedge clk_p); #1;
      end
      din_vld  = 1'b0;
      din_last = 1'b0;
   endtask

   task automatic drain(input int rnd, input int budget, output int lat);
      logic [1:0] pd;
      logic       pl, pp, stalled;
      int         bad_rdy, bad_hold, cyc;
      bit         done;
      got_q.delete();
      lat = -1; stalled = 1'b0; bad_rdy = 0; bad_hold = 0; cyc = 0; done = 0;
      pd = 2'b00; pl = 1'b0; pp = 1'b0;
      while (!done && cyc < budget) begin
         dout_rdy = (rnd != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
         @(negedge clk_p);
         cyc++;
         if (o_vld) begin
            beat_t g;
            if (lat < 0) lat = cyc;
            if (o_din_rdy !== 1'b0) bad_rdy++;
            if (stalled && ({o_dout, o_last, o_pad} !== {pd, pl, pp})) bad_hold++;
            stalled = !dout_rdy;
            pd = o_dout; pl = o_last; pp = o_pad;
            if (dout_rdy) begin
               g.d = o_dout; g.last = o_last; g.pad = o_pad;
               got_q.push_back(g);
               if (o_last) done = 1;
            end
         end else begin
            stalled = 1'b0;
         end
         @(posedge clk_p); #1;
      end
      dout_rdy = 1'b0;
      check("drain_completed", 64'(done), 1);
      check("din_rdy_low_in_drain", bad_rdy, 0);
      check("held_during_stall", bad_hold, 0);
   endtask

   task automatic compare(input string tag);
      int mm = 0;
      check({tag, "_nbeats_vs_model"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i].d !== exp_q[i].d || got_q[i].last !== exp_q[i].last ||
             got_q[i].pad !== exp_q[i].pad) mm++;
      check({tag, "_beat_mismatches"}, mm, 0);
   endtask

   task automatic post_idle(input string tag);
      @(negedge clk_p);
      check({tag, "_din_rdy_after_last"}, 64'(o_din_rdy), 1);
      check({tag, "_busy_after_last"}, 64'(o_busy), 0);
      @(posedge clk_p); #1;
   endtask

   initial begin
      vec_t tbl[6];
      int   a5_exp[8];
      int   b4_exp[4];
      int   lat, first_pad, nlast, mm, cnt_ovf, cnt_vld, n, cyc;

      a5_exp = '{1, 0, 1, 0, 0, 1, 0, 1};
      b4_exp = '{0, 1, 3, 2};
      tbl[0] = '{0,  3, 1, 0,  512,  24};
      tbl[1] = '{0, 64, 0, 0,  512, 512};
      tbl[2] = '{0, 65, 0, 0, 1024, 520};
      tbl[3] = '{1,  1, 2, 0,  256,   4};
      tbl[4] = '{0, 10, 0, 1,  512,  80};
      tbl[5] = '{1,  8, 0, 1,  256,  32};

      sel = 0; rst = 1'b1; din = 8'h00; din_vld = 1'b0; din_last = 1'b0; dout_rdy = 1'b0;
      repeat (3) @(posedge clk_p);
      #1 rst = 1'b0;
      @(negedge clk_p);
      check("reset_din_rdy", 64'(o_din_rdy), 1);
      check("reset_dout", 64'(o_dout), 0);
      check("reset_dout_vld", 64'(o_vld), 0);
      check("reset_dout_last", 64'(o_last), 0);
      check("reset_dout_pad", 64'(o_pad), 0);
      check("reset_busy", 64'(o_busy), 0);
      check("reset_ovf_err", 64'(o_ovf), 0);
      @(posedge clk_p); #1;

      for (int t = 0; t < 6; t++) begin
         sel = tbl[t].sel;
         load_words(tbl[t].fixed, tbl[t].nwords);
         send_words(tbl[t].rnd);
         drain(tbl[t].rnd, 4000, lat);
         check($sformatf("t%0d_first_vld_latency", t), lat, 2);
         build_model((sel == 0) ? 1 : 2);
         compare($sformatf("t%0d", t));
         check($sformatf("t%0d_beats", t), got_q.size(), tbl[t].exp_beats);
         first_pad = got_q.size();
         nlast = 0;
         for (int i = got_q.size() - 1; i >= 0; i--) begin
            if (got_q[i].pad) first_pad = i;
            if (got_q[i].last) nlast++;
         end
         check($sformatf("t%0d_first_pad_beat", t), first_pad, tbl[t].exp_pad_at);
         check($sformatf("t%0d_last_count", t), nlast, 1);
         if (tbl[t].fixed == 1)
            for (int i = 0; i < 8 && i < got_q.size(); i++)
               check($sformatf("a5_beat%0d", i), 64'(got_q[i].d), a5_exp[i]);
         if (tbl[t].fixed == 2)
            for (int i = 0; i < 4 && i < got_q.size(); i++)
               check($sformatf("b4_beat%0d", i), 64'(got_q[i].d), b4_exp[i]);
         post_idle($sformatf("t%0d", t));
      end

      // Same 10-word frame with and without back-pressure must give identical beats.
      sel = 0;
      load_words(0, 10);
      send_words(0);
      drain(0, 4000, lat);
      saved_q = got_q;
      post_idle("rdy_full");
      send_words(1);
      drain(1, 4000, lat);
      post_idle("rdy_rand");
      check("backpressure_nbeats", got_q.size(), saved_q.size());
      mm = 0;
      for (int i = 0; i < got_q.size() && i < saved_q.size(); i++)
         if (got_q[i].d !== saved_q[i].d || got_q[i].pad !== saved_q[i].pad ||
             got_q[i].last !== saved_q[i].last) mm++;
      check("backpressure_identical", mm, 0);

      // Overflow on the 8-word buffer, then a normal 2-word frame.
      sel = 1;
      load_words(0, 9);
      send_words(0);
      @(negedge clk_p);
      check("ovf_pulse_cycle", 64'(o_ovf), 1);
      cnt_ovf = 0; cnt_vld = 0;
      for (int i = 0; i < 10; i++) begin
         if (o_ovf) cnt_ovf++;
         if (o_vld) cnt_vld++;
         @(negedge clk_p);
      end
      check("ovf_pulse_count", cnt_ovf, 1);
      check("ovf_no_dout_vld", cnt_vld, 0);
      check("ovf_din_rdy_after", 64'(o_din_rdy), 1);
      check("ovf_busy_after", 64'(o_busy), 0);
      @(posedge clk_p); #1;
      load_words(0, 2);
      send_words(0);
      drain(0, 4000, lat);
      build_model(2);
      compare("after_ovf");
      post_idle("after_ovf");

      // Reset at beat 100 of a drain, then a fresh frame.
      sel = 0;
      load_words(0, 3);
      send_words(0);
      dout_rdy = 1'b1; n = 0; cyc = 0;
      while (n < 100 && cyc < 400) begin
         @(negedge clk_p);
         cyc++;
         if (o_vld) n++;
         @(posedge clk_p); #1;
      end
      check("beat100_reached", n, 100);
      check("beat100_presented", 64'(o_vld), 1);
      rst = 1'b1;
      #1;
      check("midrst_dout_vld", 64'(o_vld), 0);
      check("midrst_busy", 64'(o_busy), 0);
      check("midrst_din_rdy", 64'(o_din_rdy), 1);
      check("midrst_dout_last", 64'(o_last), 0);
      dout_rdy = 1'b0;
      @(posedge clk_p); #1;
      rst = 1'b0;
      @(posedge clk_p); #1;
      load_words(0, 5);
      send_words(0);
      drain(0, 4000, lat);
      check("after_rst_latency", lat, 2);
      build_model(1);
      compare("after_rst");
      post_idle("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
